// File: rtl/seven_seg_pkg.sv
// Shared 7-segment types, constants and the digit-to-segment lookup.
// Segment order everywhere is {a,b,c,d,e,f,g}, active-high (logical).
package seven_seg_pkg;

  typedef logic [6:0] seg_t;
  typedef logic [3:0] bcd_t;

  localparam seg_t SEG_BLANK = 7'b0000000;
  localparam seg_t SEG_DASH  = 7'b0000001;

  // Non-decimal nibbles decode to blank so a corrupted digit never
  // shows as a plausible number.
  function automatic seg_t seg_lookup(bcd_t d);
    case (d)
      4'd0:    return 7'b1111110;
      4'd1:    return 7'b0110000;
      4'd2:    return 7'b1101101;
      4'd3:    return 7'b1111001;
      4'd4:    return 7'b0110011;
      4'd5:    return 7'b1011011;
      4'd6:    return 7'b1011111;
      4'd7:    return 7'b1110000;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1111011;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bcd_display_driver_if.sv
// Bus between a datapath and the display driver.
//   master: load_i, bin_i, blank_lz_i out; busy_o, done_o, ovf_o, seg_o, an_o in
//   slave : the driver side (directions reversed)
interface bcd_display_driver_if #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
);
  import seven_seg_pkg::*;

  logic              load_i;
  logic [WIDTH-1:0]  bin_i;
  logic              blank_lz_i;
  logic              busy_o;
  logic              done_o;
  logic              ovf_o;
  seg_t              seg_o;
  logic [DIGITS-1:0] an_o;

  modport master (output load_i, bin_i, blank_lz_i,
                  input  busy_o, done_o, ovf_o, seg_o, an_o);
  modport slave  (input  load_i, bin_i, blank_lz_i,
                  output busy_o, done_o, ovf_o, seg_o, an_o);
endinterface

// File: rtl/bcd_seg_decoder.sv
// Combinational BCD nibble -> 7-segment pattern.
//   digit : BCD nibble in
//   seg   : {a..g} out, active-high
module bcd_seg_decoder
  import seven_seg_pkg::*;
(
  input  bcd_t digit,
  output seg_t seg
);
  assign seg = seg_lookup(digit);
endmodule

// File: rtl/bcd_display_driver.sv
// Multi-digit 7-segment driver: sequential double-dabble binary->BCD
// (one shift per cycle), a display register, and a time-multiplexed
// scan of the digits onto one shared segment bus.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of bcd_display_driver_if (load/bin/blank in;
//              busy/done/ovf/seg/an out)
module bcd_display_driver
  import seven_seg_pkg::*;
#(
  parameter int WIDTH      = 14,
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 50000,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input logic clk,
  input logic rst,
  bcd_display_driver_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BCD_W = 4 * DIGITS;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // ---------------- conversion ----------------
  logic [0:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   bin_sr;
  bcd_t [DIGITS-1:0]  bcd_w, bcd_adj, disp;
  logic [BCD_W-1:0]   adj_flat, bcd_shift;
  logic               ovf_w, ovf, done;

  always_comb begin
    bcd_adj = bcd_w;
    for (int i = 0; i < DIGITS; i++)
      if (bcd_w[i] >= 4'd5) bcd_adj[i] = bcd_w[i] + 4'd3;
  end

  assign adj_flat  = bcd_adj;
  assign bcd_shift = {adj_flat[BCD_W-2:0], bin_sr[WIDTH-1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      bin_sr <= '0;
      bcd_w  <= '0;
      ovf_w  <= 1'b0;
      disp   <= '0;
      ovf    <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (bus.load_i) begin
          state  <= ST_BUSY;
          cnt    <= '0;
          bin_sr <= bus.bin_i;
          bcd_w  <= '0;
          ovf_w  <= 1'b0;
        end
        ST_BUSY: begin
          bcd_w  <= bcd_shift;
          bin_sr <= bin_sr << 1;
          // a 1 leaving the top nibble means the value needs more digits
          ovf_w  <= ovf_w | adj_flat[BCD_W-1];
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state <= ST_IDLE;
            done  <= 1'b1;
            disp  <= bcd_shift;
            ovf   <= ovf_w | adj_flat[BCD_W-1];
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // ---------------- scan ----------------
  logic [DIV_W-1:0]  div;
  logic [IDX_W-1:0]  idx;
  logic [DIGITS-1:0] an_r;
  seg_t              seg_r, dec_seg, seg_next;
  bcd_t              cur;
  logic              lead_zero;

  bcd_seg_decoder u_dec (.digit(cur), .seg(dec_seg));

  // lead_zero: current digit and everything above it are zero
  always_comb begin
    cur       = disp[idx];
    lead_zero = 1'b1;
    for (int j = 0; j < DIGITS; j++)
      if (j >= int'(idx) && disp[j] != 4'd0) lead_zero = 1'b0;
    if (ovf)
      seg_next = SEG_DASH;
    else if (bus.blank_lz_i && idx != '0 && lead_zero)
      seg_next = SEG_BLANK;
    else
      seg_next = dec_seg;
  end

  // an/seg are both registered from the same idx so they switch together
  always_ff @(posedge clk) begin
    if (rst) begin
      div   <= '0;
      idx   <= '0;
      an_r  <= '0;
      seg_r <= SEG_BLANK;
    end else begin
      if (div == DIV_LAST) begin
        div <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        div <= div + 1'b1;
      end
      an_r  <= DIGITS'(1) << idx;
      seg_r <= seg_next;
    end
  end

  assign bus.busy_o = (state == ST_BUSY);
  assign bus.done_o = done;
  assign bus.ovf_o  = ovf;
  assign bus.seg_o  = seg_r ^ {7{ACTIVE_LOW}};
  assign bus.an_o   = an_r ^ {DIGITS{ACTIVE_LOW}};

endmodule

// File: tb/tb_bcd_display_driver.sv
// Self-checking bench for bcd_display_driver: an arithmetic reference
// model checked every cycle, plus directed literal expectations.
module tb_bcd_display_driver;
  import seven_seg_pkg::*;

  localparam int WIDTH = 14, DIGITS = 4, SCAN_DIV = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bcd_display_driver_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();
  bcd_display_driver_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus_al ();

  bcd_display_driver #(.WIDTH(WIDTH), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV),
                       .ACTIVE_LOW(1'b0)) dut (.clk(clk), .rst(rst), .bus(bus));
  bcd_display_driver #(.WIDTH(WIDTH), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV),
                       .ACTIVE_LOW(1'b1)) dut_al (.clk(clk), .rst(rst), .bus(bus_al));

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0b expected %0b", nm, act, exp);
    end
  endtask

  seg_t seg_tbl [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                         7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

  function automatic int pow10(input int p);
    int r = 1;
    for (int i = 0; i < p; i++) r = r * 10;
    return r;
  endfunction

  function automatic seg_t exp_digit(input int val, input bit ovf, input bit blank, input int p);
    if (ovf) return 7'b0000001;
    if (p > 0 && blank && val < pow10(p)) return 7'b0000000;
    return seg_tbl[(val / pow10(p)) % 10];
  endfunction

  // ---------------- reference model ----------------
  int   m_edges, m_busy_left, m_pending, m_val;
  bit   m_done, m_ovf, m_started = 0;
  seg_t m_seg;
  logic [DIGITS-1:0] m_an;

  always @(posedge clk) begin
    int p;
    m_started = 1;
    if (rst) begin
      m_edges = 0; m_busy_left = 0; m_done = 0; m_val = 0; m_ovf = 0;
      m_seg = '0; m_an = '0;
    end else begin
      m_edges++;
      p = ((m_edges - 1) / SCAN_DIV) % DIGITS;
      m_an  = DIGITS'(1 << p);
      m_seg = exp_digit(m_val, m_ovf, bus.blank_lz_i, p);
      m_done = 0;
      if (m_busy_left > 0) begin
        m_busy_left--;
        if (m_busy_left == 0) begin
          m_done = 1;
          m_val  = m_pending % pow10(DIGITS);
          m_ovf  = (m_pending > pow10(DIGITS) - 1);
        end
      end else if (bus.load_i) begin
        m_busy_left = WIDTH;
        m_pending   = int'(bus.bin_i);
      end
    end
  end

  always @(negedge clk) begin
    logic [DIGITS-1:0] an_al_exp;
    if (m_started) begin
      an_al_exp = ~m_an;
      chk("busy", bus.busy_o, m_busy_left > 0);
      chk("done", bus.done_o, m_done);
      chk("ovf",  bus.ovf_o,  m_ovf);
      chk("seg",  bus.seg_o,  m_seg);
      chk("an",   bus.an_o,   m_an);
      chk("an_al", bus_al.an_o, an_al_exp);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_done(input string nm);
    int n = 0;
    while (bus.done_o !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    chk(nm, n, 14);
  endtask

  task automatic do_load(input int v);
    @(negedge clk); bus.load_i = 1'b1; bus.bin_i = 14'(v);
    @(negedge clk); bus.load_i = 1'b0;
    wait_done($sformatf("done_latency_%0d", v));
  endtask

  task automatic scan_check(input string nm, input seg_t s0, s1, s2, s3);
    seg_t e [4];
    int n = 0;
    e = '{s0, s1, s2, s3};
    while (bus.an_o !== 4'b1000 && n < 40) begin @(negedge clk); n++; end
    while (bus.an_o !== 4'b0001 && n < 40) begin @(negedge clk); n++; end
    chk({nm, "_sync"}, n < 40, 1);
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("%s_an%0d", nm, p), bus.an_o, 1 << p);
      chk($sformatf("%s_seg%0d", nm, p), bus.seg_o, e[p]);
      repeat (SCAN_DIV) @(negedge clk);
    end
  endtask

  initial begin
    int k, nd;
    bus.load_i = 0; bus.bin_i = '0; bus.blank_lz_i = 0;
    bus_al.load_i = 0; bus_al.bin_i = '0; bus_al.blank_lz_i = 0;
    rst = 1'b1;

    // 1. reset state and first cycle after release
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_seg", bus.seg_o, 7'b0000000);
    chk("rst_an", bus.an_o, 4'b0000);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_done", bus.done_o, 0);
    chk("rst_ovf", bus.ovf_o, 0);
    chk("rst_seg_al", bus_al.seg_o, 7'b1111111);
    chk("rst_an_al", bus_al.an_o, 4'b1111);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_an", bus.an_o, 4'b0001);
    chk("rel_seg", bus.seg_o, 7'b1111110);
    chk("rel_an_al", bus_al.an_o, 4'b1110);
    chk("rel_seg_al", bus_al.seg_o, 7'b0000001);

    // 2. basic conversion and scan
    do_load(1234);
    scan_check("v1234", 7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000);

    // 3. leading-zero blanking
    bus.blank_lz_i = 1;
    do_load(7);
    scan_check("v7_blank", 7'b1110000, 7'b0000000, 7'b0000000, 7'b0000000);
    bus.blank_lz_i = 0;
    scan_check("v7_noblank", 7'b1110000, 7'b1111110, 7'b1111110, 7'b1111110);
    bus.blank_lz_i = 1;
    do_load(0);
    scan_check("v0_blank", 7'b1111110, 7'b0000000, 7'b0000000, 7'b0000000);
    bus.blank_lz_i = 0;

    // 4. overflow, then cleared by next conversion
    do_load(12000);
    chk("ovf_set", bus.ovf_o, 1);
    scan_check("ovf", 7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001);
    do_load(42);
    chk("ovf_clr", bus.ovf_o, 0);
    scan_check("v42", 7'b1101101, 7'b0110011, 7'b1111110, 7'b1111110);

    // 5. load while busy ignored; load in done cycle accepted
    @(negedge clk); bus.load_i = 1; bus.bin_i = 14'd99;
    @(negedge clk); bus.load_i = 0; k = 1;
    repeat (4) begin @(negedge clk); k++; end
    bus.load_i = 1; bus.bin_i = 14'd5000;
    @(negedge clk); bus.load_i = 0; k++;
    while (bus.done_o !== 1'b1 && k < 40) begin @(negedge clk); k++; end
    chk("busy_load_done_at", k, 15);
    bus.load_i = 1; bus.bin_i = 14'd321;
    @(negedge clk); bus.load_i = 0;
    chk("b2b_busy", bus.busy_o, 1);
    wait_done("b2b_latency");
    scan_check("v321", 7'b0110000, 7'b1101101, 7'b1111001, 7'b1111110);

    // 6. reset mid-conversion
    @(negedge clk); bus.load_i = 1; bus.bin_i = 14'd8888;
    @(negedge clk); bus.load_i = 0;
    repeat (7) @(negedge clk);
    chk("busy_cycle8", bus.busy_o, 1);
    rst = 1;
    @(negedge clk);
    chk("abort_busy", bus.busy_o, 0);
    rst = 0;
    nd = 0;
    repeat (20) begin @(negedge clk); if (bus.done_o === 1'b1) nd++; end
    chk("abort_no_done", nd, 0);
    scan_check("abort", 7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
